// File: rtl/dsdaccel_pkg.sv
// Shared types and sizes for the image-buffer write path.
//   packer_state_t : frame sequencing states of the packer
//   byte_t         : one stream byte
//   LANES          : byte lanes per input beat (and bytes per 128-bit word)
//   STAGE_BYTES    : staging buffer depth in bytes
package dsdaccel_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} packer_state_t;

  typedef logic [7:0] byte_t;

  localparam int LANES       = 16;
  localparam int STAGE_BYTES = 32;

endpackage

// File: rtl/dsdaccel_byte_appender.sv
// Combinational byte merge: places the first cnt lanes of a beat into the
// staging image starting at byte offset fill. Positions outside
// [fill, fill+cnt) keep their staged value.
//   stage  : current staging bytes (byte 0 = oldest)
//   fill   : number of bytes already staged (0..15)
//   lanes  : beat bytes, lane 0 earliest
//   cnt    : valid lanes this beat, already clamped to 0..16
//   merged : staging image after the append
module dsdaccel_byte_appender
  import dsdaccel_pkg::*;
(
  input  byte_t [0:STAGE_BYTES-1] stage,
  input  logic  [4:0]             fill,
  input  byte_t [0:LANES-1]       lanes,
  input  logic  [4:0]             cnt,
  output byte_t [0:STAGE_BYTES-1] merged
);

  logic [5:0] lo;
  logic [5:0] hi;

  assign lo = {1'b0, fill};
  assign hi = {1'b0, fill} + {1'b0, cnt};

  always_comb begin
    merged = stage;
    for (int p = 0; p < STAGE_BYTES; p++) begin
      if ((6'(p) >= lo) && (6'(p) < hi)) begin
        merged[p] = lanes[4'(p - int'(fill))];
      end
    end
  end

endmodule

// File: rtl/dsdaccel_imgpacker.sv
// Packs a byte stream of 1..16-byte beats into contiguous 128-bit big-endian
// words and writes each full word to the image buffer. A partial tail word is
// zero-padded and written in a FLUSH cycle before the done pulse.
//   i_CLK, i_RST          : clock, synchronous active-high reset
//   i_START, i_BASE_ADDR  : start/abort a frame at the given word address
//   i_DIN, i_DIN_CNT      : beat lanes and valid lane count (>16 treated as 16)
//   i_DIN_VALID, i_LAST   : beat valid, last beat of frame
//   o_DIN_READY           : high in RUN only
//   o_WE, o_WADDR, o_WDATA: registered word write (stream byte 0 in bits 127:120)
//   o_BUSY                : high in RUN/FLUSH
//   o_DONE                : one-cycle pulse the cycle after the frame's final write
module dsdaccel_imgpacker
  import dsdaccel_pkg::*;
#(
  parameter int IAW = 10
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_START,
  input  logic [IAW-1:0]       i_BASE_ADDR,
  input  byte_t [0:LANES-1]    i_DIN,
  input  logic [4:0]           i_DIN_CNT,
  input  logic                 i_DIN_VALID,
  output logic                 o_DIN_READY,
  input  logic                 i_LAST,
  output logic                 o_WE,
  output logic [IAW-1:0]       o_WADDR,
  output logic [127:0]         o_WDATA,
  output logic                 o_BUSY,
  output logic                 o_DONE
);

  packer_state_t                state, state_n;
  logic [4:0]                   fill, fill_n;
  logic [IAW-1:0]               addr, addr_n;
  byte_t [0:STAGE_BYTES-1]      staging, staging_n, merged;
  logic                         we_n, done_n;
  logic [IAW-1:0]               waddr_n;
  logic [127:0]                 wdata_n;
  logic [4:0]                   cnt;
  logic [4:0]                   sum;

  function automatic logic [4:0] clamp_cnt(input logic [4:0] c);
    return (c > 5'd16) ? 5'd16 : c;
  endfunction

  // Tail word: bytes at or beyond fill are forced to zero.
  function automatic logic [127:0] flush_word(input byte_t [0:STAGE_BYTES-1] stg,
                                              input logic [4:0] f);
    byte_t [0:LANES-1] w;
    for (int k = 0; k < LANES; k++) begin
      w[k] = (5'(k) < f) ? stg[k] : 8'h00;
    end
    return w;
  endfunction

  assign cnt = clamp_cnt(i_DIN_CNT);
  // fill <= 15 and cnt <= 16, so the 5-bit sum never overflows.
  assign sum = fill + cnt;

  dsdaccel_byte_appender u_append (
    .stage  (staging),
    .fill   (fill),
    .lanes  (i_DIN),
    .cnt    (cnt),
    .merged (merged)
  );

  assign o_DIN_READY = (state == RUN);
  assign o_BUSY      = (state == RUN) || (state == FLUSH);

  always_comb begin
    state_n   = state;
    fill_n    = fill;
    addr_n    = addr;
    staging_n = staging;
    we_n      = 1'b0;
    waddr_n   = o_WADDR;
    wdata_n   = o_WDATA;
    // A start issued in DONE still reports the finished frame.
    done_n    = (state == DONE);

    if (i_START) begin
      // Start or abort: staged bytes are discarded without a write.
      state_n   = RUN;
      fill_n    = 5'd0;
      addr_n    = i_BASE_ADDR;
      staging_n = '0;
    end else begin
      case (state)
        RUN: begin
          if (i_DIN_VALID) begin
            if (sum[4]) begin
              we_n      = 1'b1;
              waddr_n   = addr;
              wdata_n   = merged[0:LANES-1];
              staging_n = {merged[LANES:STAGE_BYTES-1], {LANES{8'h00}}};
              fill_n    = sum - 5'd16;
              addr_n    = addr + 1'b1;
            end else begin
              staging_n = merged;
              fill_n    = sum;
            end
            if (i_LAST) begin
              state_n = (fill_n != 5'd0) ? FLUSH : DONE;
            end
          end
        end
        FLUSH: begin
          we_n      = 1'b1;
          waddr_n   = addr;
          wdata_n   = flush_word(staging, fill);
          addr_n    = addr + 1'b1;
          fill_n    = 5'd0;
          staging_n = '0;
          state_n   = DONE;
        end
        DONE:    state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  // Register stage: state, staging and all write-port outputs.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= IDLE;
      fill    <= 5'd0;
      addr    <= '0;
      staging <= '0;
      o_WE    <= 1'b0;
      o_WADDR <= '0;
      o_WDATA <= '0;
      o_DONE  <= 1'b0;
    end else begin
      state   <= state_n;
      fill    <= fill_n;
      addr    <= addr_n;
      staging <= staging_n;
      o_WE    <= we_n;
      o_WADDR <= waddr_n;
      o_WDATA <= wdata_n;
      o_DONE  <= done_n;
    end
  end

endmodule
